// File: rtl/irq_pkg.sv
// Shared types for the interrupt controller: per-channel state encoding
// and the layout of the configuration write word.
package irq_pkg;

  localparam int MAX_IRQ = 31;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PENDING    = 2'd1,
    IN_SERVICE = 2'd2
  } chan_state_e;

  // cfg_wdata is {edge_mode, enable, prio}; these offsets count upward from
  // the first bit above the prio field.
  localparam int CFG_ENABLE_OFS = 0;
  localparam int CFG_EDGE_OFS   = 1;

endpackage

// File: rtl/irq_gateway.sv
// One interrupt channel: two-flop synchroniser, rising-edge detect, and the
// IDLE/PENDING/IN_SERVICE tracker with a single held "repend" edge.
module irq_gateway
  import irq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        src,
  input  logic        edge_mode,
  input  logic        claim_hit,
  input  logic        complete_hit,
  output chan_state_e state
);

  logic        sync1_q, sync2_q, prev_q;
  logic        repend_q, repend_d;
  chan_state_e state_d;
  logic        rise, edge_ev, level_ev, trigger;

  assign rise     = sync2_q & ~prev_q;
  assign edge_ev  = edge_mode & rise;
  assign level_ev = ~edge_mode & sync2_q;
  assign trigger  = edge_ev | level_ev;

  // Bring the asynchronous source into the clock domain and keep one
  // extra stage so a 0->1 transition can be seen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Channel state and repend registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      repend_q <= 1'b0;
    end else begin
      state    <= state_d;
      repend_q <= repend_d;
    end
  end

  // Next-state logic; complete only matters in IN_SERVICE, claim only in
  // PENDING, so a same-cycle claim+complete resolves naturally.
  always_comb begin
    state_d  = state;
    repend_d = repend_q;
    case (state)
      IDLE: begin
        if (trigger) state_d = PENDING;
      end
      PENDING: begin
        if (claim_hit) state_d = IN_SERVICE;
        if (edge_ev) repend_d = 1'b1;
      end
      IN_SERVICE: begin
        if (complete_hit) begin
          if (repend_q) begin
            state_d  = PENDING;
            repend_d = edge_ev;
          end else if (trigger) begin
            state_d = PENDING;
          end else begin
            state_d = IDLE;
          end
        end else if (edge_ev) begin
          repend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/irq_controller.sv
// Priority interrupt controller: per-channel gateways, configuration
// registers, and a registered highest-priority arbiter.
//
// Request/claim protocol: irq_req/irq_id form a level "valid" that the core
// may observe at any time. A one-cycle claim pulse is the "ready": it accepts
// whatever irq_id shows in that cycle, and the named channel is removed from
// arbitration at the same edge. complete/complete_id is an independent
// one-cycle pulse that releases a channel from IN_SERVICE.
module irq_controller
  import irq_pkg::*;
#(
  parameter  int NUM_IRQ = 4,
  parameter  int PRIO_W  = 3,
  localparam int ID_W    = $clog2(NUM_IRQ + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  irq_src,
  input  logic                cfg_wr,
  input  logic [ID_W-1:0]     cfg_addr,
  input  logic [PRIO_W+1:0]   cfg_wdata,
  output logic                irq_req,
  output logic [ID_W-1:0]     irq_id,
  input  logic                claim,
  input  logic                complete,
  input  logic [ID_W-1:0]     complete_id
);

  if (NUM_IRQ < 1 || NUM_IRQ > MAX_IRQ) begin : g_bad_num_irq
    $error("irq_controller: NUM_IRQ must be in 1..31");
  end

  logic [PRIO_W-1:0]  prio_q [NUM_IRQ];
  logic [NUM_IRQ-1:0] enable_q, edge_q;
  logic [PRIO_W-1:0]  threshold_q;
  logic [NUM_IRQ-1:0] claim_hit, complete_hit;
  chan_state_e        chan_state [NUM_IRQ];
  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  win_prio;

  logic [PRIO_W-1:0]  cfg_prio;
  logic               cfg_en, cfg_edge;

  assign cfg_prio = cfg_wdata[PRIO_W-1:0];
  assign cfg_en   = cfg_wdata[PRIO_W + CFG_ENABLE_OFS];
  assign cfg_edge = cfg_wdata[PRIO_W + CFG_EDGE_OFS];

  // Configuration registers; address 0 is the threshold, out-of-range
  // addresses match nothing and are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      threshold_q <= '0;
      enable_q    <= '0;
      edge_q      <= '0;
      for (int i = 0; i < NUM_IRQ; i++) prio_q[i] <= '0;
    end else if (cfg_wr) begin
      if (cfg_addr == '0) threshold_q <= cfg_prio;
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (cfg_addr == ID_W'(i + 1)) begin
          prio_q[i]   <= cfg_prio;
          enable_q[i] <= cfg_en;
          edge_q[i]   <= cfg_edge;
        end
      end
    end
  end

  // Decode which channel the claim and complete pulses refer to.
  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      claim_hit[i]    = claim && (irq_id == ID_W'(i + 1));
      complete_hit[i] = complete && (complete_id == ID_W'(i + 1));
    end
  end

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
    irq_gateway u_gateway (
      .clk          (clk),
      .rst          (rst),
      .src          (irq_src[g]),
      .edge_mode    (edge_q[g]),
      .claim_hit    (claim_hit[g]),
      .complete_hit (complete_hit[g]),
      .state        (chan_state[g])
    );
  end

  // Highest priority wins; scanning upward with a strict compare keeps the
  // lowest ID on ties. The channel being claimed this cycle is skipped.
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (chan_state[i] == PENDING && enable_q[i] && prio_q[i] != '0 &&
          prio_q[i] > threshold_q && !claim_hit[i] && prio_q[i] > win_prio) begin
        win_id   = ID_W'(i + 1);
        win_prio = prio_q[i];
      end
    end
  end

  // Registered request outputs toward the core.
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_req <= 1'b0;
      irq_id  <= '0;
    end else begin
      irq_req <= (win_id != '0);
      irq_id  <= win_id;
    end
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, meaning the number of interrupt source channels, legal range 1..31.
REQ-002 SHALL have parameter PRIO_W, default 3, meaning the priority field width in bits.
REQ-003 SHALL have local parameter ID_W = $clog2(NUM_IRQ+1); ID 0 means "no interrupt", and channels are numbered 1..NUM_IRQ.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port irq_src, input, NUM_IRQ bits: asynchronous sources; bit i-1 is channel i.
REQ-007 SHALL have port cfg_wr, input, 1 bit: one-cycle configuration write strobe.
REQ-008 SHALL have port cfg_addr, input, ID_W bits: value 1..NUM_IRQ selects that channel's config; value 0 selects the threshold.
REQ-009 SHALL have port cfg_wdata, input, PRIO_W+2 bits: {edge_mode, enable, prio}; for the threshold, only the prio field is used.
REQ-010 SHALL have port irq_req, input-to-core direction output, 1 bit: registered request line to the core CSR/trap logic.
REQ-011 SHALL have port irq_id, output, ID_W bits: registered ID of the current winning channel, 0 when irq_req is low.
REQ-012 SHALL have port claim, input, 1 bit: one-cycle pulse from the core accepting the interrupt named by irq_id.
REQ-013 SHALL have port complete, input, 1 bit: one-cycle pulse signalling that the handler has finished.
REQ-014 SHALL have port complete_id, input, ID_W bits: the channel being completed.

Function
REQ-015 SHALL synchronise each irq_src bit through two flops before any use.
REQ-016 SHALL keep, per channel, one of three states: IDLE, PENDING or IN_SERVICE, plus a one-bit "repend" flag.
REQ-017 SHALL, in edge mode, move IDLE->PENDING on a synchronised 0->1 transition.
REQ-018 SHALL, in level mode, move IDLE->PENDING while the synchronised input is high.
REQ-019 SHALL, in edge mode, set repend when a rising edge arrives while the channel is PENDING or IN_SERVICE; further edges do not count, so at most one edge is held.
REQ-020 SHALL treat a channel as eligible only when it is PENDING, enable=1, prio>0 and prio>threshold.
REQ-021 SHALL select the eligible channel with the highest prio; ties go to the lowest ID.
REQ-022 SHALL register irq_req and irq_id from the arbitration result each cycle.
REQ-023 SHALL give a latency of 4 rising edges, including the sampling edge, from irq_src rising to irq_req high, for an idle, enabled channel.
REQ-024 SHALL, on claim with irq_id=k≠0, move channel k PENDING->IN_SERVICE at that edge; channel k is excluded from arbitration at the same edge.
REQ-025 SHALL treat claim while irq_id=0 as a no-op.
REQ-026 SHALL, on complete with complete_id=k and channel k IN_SERVICE, move channel k to PENDING if repend=1 (clearing repend) or if it is level mode with input high; otherwise to IDLE.
REQ-027 SHALL ignore complete for a channel that is not IN_SERVICE, or for complete_id=0 or complete_id>NUM_IRQ.
REQ-028 SHALL apply claim and complete in the same cycle to different channels independently.
REQ-029 SHALL, when claim and complete in the same cycle target the same channel, give precedence to complete; the channel ends in IN_SERVICE only if it was PENDING.
REQ-030 SHALL take effect for a cfg write at the next edge; arbitration in the following cycle uses the new value.
REQ-031 SHALL keep a PENDING channel's state when it is disabled: the channel is masked, not cleared.
REQ-032 SHALL ignore cfg writes with cfg_addr>NUM_IRQ.
REQ-033 SHALL support at most 31 channels.

Reset
REQ-034 SHALL, while rst=0 at a rising edge, clear all channels to IDLE with repend=0, enable=0, prio=0, edge_mode=0, threshold=0, synchroniser flops=0, irq_req=0 and irq_id=0.
REQ-035 SHALL discard all in-flight pending and in-service state on a reset asserted mid-operation; the first request after release needs the full REQ-023 latency.

Structure
REQ-036 SHALL place the channel state enum (IDLE/PENDING/IN_SERVICE) and the cfg field packing in shared package irq_pkg.
REQ-037 SHALL have one per-channel sub-module, irq_gateway (synchroniser, edge detect, state, repend), instantiated NUM_IRQ times; the arbiter stays in the top level.

Verification
REQ-038 SHALL cover: channel 2 configured edge, enable, prio=3, threshold 0; pulse src[1] -> irq_req=1 and irq_id=2 at edge 4; claim -> irq_req=0 next cycle; complete(2) -> IDLE.
REQ-039 SHALL cover: channels 1 and 3 both prio=5 and pending -> irq_id=1; claim -> irq_id=3 next cycle.
REQ-040 SHALL cover: channel 4 with prio=2 and threshold=2 -> no irq_req; write threshold=1 -> irq_req with irq_id=4 two cycles after the write.
REQ-041 SHALL cover: edge channel 1 receives two edges while IN_SERVICE -> after complete, exactly one new request with irq_id=1; after the second complete, IDLE.
REQ-042 SHALL cover: level channel 2 held high, claim then complete -> re-request with irq_id=2; complete_id=3 while 3 is IDLE -> no change.
REQ-043 SHALL cover: rst=0 asserted while channel 1 is IN_SERVICE and channel 2 is PENDING -> irq_req=0, irq_id=0 and all configuration cleared after the reset edge.
